muskbus_arbiter: RTL and testbench
==================================

# muskbus_arbiter

Round-robin arbiter that shares one downstream Muskbus port (toward memory/MMIO) among N_CLIENTS upstream requesters (e.g. instruction fetch, data cache). Grants are locked for a whole transaction: an address beat plus BEATS write-data beats, or an address beat plus BEATS read-response beats. Sits between the core-side bus masters and the system bus top.

## Interface
- N_CLIENTS, 2: number of upstream requesters (2..8).
- BEATS, 8: data beats per transaction (64-bit each).
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- c_bid  in  N_CLIENTS  per-client bus bid; OR'd into m_bid only.
- c_req  in  64*N_CLIENTS  per-client request word; slice i = client i.
- c_reqtag  in  13*N_CLIENTS  per-client tag; bit 12 = READ(1)/WRITE(0).
- c_reqcyc  in  N_CLIENTS  per-client request valid.
- c_reqack  out  N_CLIENTS  request-beat accept, only to grantee.
- c_resp  out  64  response word, broadcast to all clients.
- c_respcyc  out  N_CLIENTS  response valid, only to grantee.
- c_respack  in  N_CLIENTS  per-client response accept.
- m_bid, m_req[64], m_reqtag[13], m_reqcyc, m_respack  out  downstream master side.
- m_reqack, m_resp[64], m_respcyc  in  downstream slave side.
- grant  out  N_CLIENTS  one-hot current owner, 0 when idle.
- stray_resp  out  1  one-cycle pulse: m_respcyc with no read outstanding.

## Operation
- States: IDLE, ADDR, WDATA, RDATA.
- IDLE: if any c_reqcyc set, pick winner by round robin starting at rr_ptr; register grant, latch winner's tag bit 12 as is_read, go ADDR. No request: stay.
- ADDR: m_req/m_reqtag/m_reqcyc = grantee's inputs (mux by grant); c_reqack[grantee] = m_reqack. On m_reqack & m_reqcyc: beat_cnt <= 0; go RDATA if is_read else WDATA.
- WDATA: forward grantee's c_reqcyc/c_req as in ADDR; each accepted beat (m_reqcyc & m_reqack) increments beat_cnt; on beat BEATS-1 accepted go IDLE.
- RDATA: m_reqcyc = 0; c_resp = m_resp; c_respcyc[grantee] = m_respcyc; m_respack = c_respack[grantee]. Each m_respcyc & m_respack increments beat_cnt; on beat BEATS-1 go IDLE.
- On return to IDLE: rr_ptr <= grantee+1 mod N_CLIENTS; grant <= 0.
- Non-grantees: c_reqack and c_respcyc held 0 at all times; their requests wait.
- m_respcyc outside RDATA: c_respcyc all 0, m_respack 0, stray_resp pulses next cycle.
- m_bid = (state != IDLE) | (|c_bid) | (|c_reqcyc).
- beat_cnt width $clog2(BEATS); compare against BEATS-1, no wrap beyond.

## Timing
- Reset (async assert): state IDLE, grant 0, rr_ptr 0, beat_cnt 0, stray_resp 0; hence all outputs 0 except c_resp = m_resp (pass-through).
- Arbitration latency: c_reqcyc seen in IDLE at edge t -> grant and m_reqcyc valid in cycle t+1.
- Forwarding in ADDR/WDATA/RDATA is combinational through the grant mux; no added latency per beat.
- Back-to-back: last beat at edge t -> IDLE in t+1; next grant earliest t+2 (one idle bubble).
- Client must hold c_reqcyc/c_req stable until its c_reqack; arbiter never drops a held request.
- Simultaneous requests from all clients: serviced in order rr_ptr, rr_ptr+1, ...; no client waits more than N_CLIENTS-1 transactions.
- Grantee deasserting c_reqcyc mid-transaction: arbiter stalls in current state (no timeout).
- Reset mid-transaction: immediate abort to IDLE; downstream is reset by same signal.

## Structure
- Add to MUSKBUS package: arb_state_t enum (IDLE, ADDR, WDATA, RDATA), TAG_RW_BIT = 12.
- Sub-module muskbus_rr_picker: inputs req vector and rr_ptr, output one-hot winner (combinational, rotate-priority-encode-rotate).
- Arbiter top holds state, grant, rr_ptr, beat_cnt and the muxes.

## Test plan
- Single read, client 0, tag 13'h1100: one grant cycle later m_reqcyc=1; after 8 m_respcyc beats c_respcyc[0] seen 8 times, back to IDLE, grant=0.
- Single write, client 1, tag 13'h0100: address + 8 data beats forwarded in order with c_reqack[1] each; c_reqack[0] stays 0.
- Both clients request reads continuously: grants alternate 01,10,01,10; rr_ptr toggles after each transaction.
- m_respcyc=1 while IDLE: stray_resp pulses for one cycle; no c_respcyc asserted; state unchanged.
- reset low during RDATA beat 3: state IDLE, grant 0, all outputs 0 asynchronously; after release client 0 wins first.
- Downstream reqack held low 20 cycles in ADDR: m_reqcyc and grant stable, no beat counted, no other client granted.

Source files
------------

// File: rtl/muskbus_pkg.sv
// Shared Muskbus types and constants used by the arbiter and its picker.
package muskbus_pkg;

    localparam int DATA_W     = 64;
    localparam int TAG_W      = 13;
    localparam int TAG_RW_BIT = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } arb_state_t;

    // True when a request tag marks a read transaction.
    function automatic logic tag_is_read(input logic [TAG_W-1:0] tag);
        return tag[TAG_RW_BIT];
    endfunction

endpackage

// File: rtl/muskbus_rr_picker.sv
// Round-robin one-hot picker: rotate requests so rr_ptr is bit 0, take the
// lowest set bit, rotate the choice back into client numbering.
module muskbus_rr_picker #(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N-1:0]     winner
);

    logic [2*N-1:0] dbl_s;
    logic [2*N-1:0] back_s;
    logic [N-1:0]   rot_s;
    logic [N-1:0]   pick_s;
    logic           found_s;

    // Rotate, priority-encode from bit 0, rotate back.
    always_comb begin
        dbl_s   = {req, req} >> rr_ptr;
        rot_s   = dbl_s[N-1:0];
        pick_s  = '0;
        found_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            pick_s[i] = rot_s[i] & ~found_s;
            found_s   = found_s | rot_s[i];
        end
        back_s = {pick_s, pick_s} << rr_ptr;
        winner = back_s[2*N-1:N];
    end

endmodule

// File: rtl/muskbus_arbiter.sv
// Round-robin arbiter sharing one downstream Muskbus port among N_CLIENTS
// requesters; the grant is held for the address beat plus BEATS data beats.
module muskbus_arbiter
    import muskbus_pkg::*;
#(
    parameter int N_CLIENTS = 2,
    parameter int BEATS     = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_CLIENTS-1:0]        c_bid,
    input  logic [DATA_W*N_CLIENTS-1:0] c_req,
    input  logic [TAG_W*N_CLIENTS-1:0]  c_reqtag,
    input  logic [N_CLIENTS-1:0]        c_reqcyc,
    output logic [N_CLIENTS-1:0]        c_reqack,
    output logic [DATA_W-1:0]           c_resp,
    output logic [N_CLIENTS-1:0]        c_respcyc,
    input  logic [N_CLIENTS-1:0]        c_respack,
    output logic                        m_bid,
    output logic [DATA_W-1:0]           m_req,
    output logic [TAG_W-1:0]            m_reqtag,
    output logic                        m_reqcyc,
    output logic                        m_respack,
    input  logic                        m_reqack,
    input  logic [DATA_W-1:0]           m_resp,
    input  logic                        m_respcyc,
    output logic [N_CLIENTS-1:0]        grant,
    output logic                        stray_resp
);

    localparam int PTR_W  = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    arb_state_t             state_r;
    arb_state_t             state_nxt_s;
    logic [N_CLIENTS-1:0]   grant_r;
    logic [PTR_W-1:0]       rr_ptr_r;
    logic [BEAT_W-1:0]      beat_cnt_r;
    logic                   is_read_r;
    logic                   stray_r;

    logic [N_CLIENTS-1:0]   winner_s;
    logic                   any_req_s;
    logic                   win_rd_s;
    logic [PTR_W-1:0]       grant_idx_s;
    logic [PTR_W-1:0]       ptr_next_s;
    logic [DATA_W-1:0]      sel_req_s;
    logic [TAG_W-1:0]       sel_tag_s;
    logic                   sel_reqcyc_s;
    logic                   sel_respack_s;
    logic                   req_beat_s;
    logic                   resp_beat_s;
    logic                   last_beat_s;
    logic                   txn_done_s;

    muskbus_rr_picker #(
        .N     (N_CLIENTS),
        .PTR_W (PTR_W)
    ) u_picker (
        .req    (c_reqcyc),
        .rr_ptr (rr_ptr_r),
        .winner (winner_s)
    );

    assign any_req_s   = |c_reqcyc;
    assign last_beat_s = (beat_cnt_r == LAST_BEAT);
    assign req_beat_s  = sel_reqcyc_s & m_reqack;
    assign resp_beat_s = m_respcyc & sel_respack_s;
    assign txn_done_s  = (state_r != IDLE) && (state_nxt_s == IDLE);
    assign ptr_next_s  = (grant_idx_s == PTR_W'(N_CLIENTS - 1)) ? '0 : grant_idx_s + PTR_W'(1);

    // Read/write kind of the client about to be granted.
    always_comb begin
        win_rd_s = 1'b0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            win_rd_s = win_rd_s | (winner_s[i] & tag_is_read(c_reqtag[i*TAG_W +: TAG_W]));
        end
    end

    // AND-OR grant mux; grant is one-hot or zero, so the OR never overlaps.
    always_comb begin
        grant_idx_s   = '0;
        sel_req_s     = '0;
        sel_tag_s     = '0;
        sel_reqcyc_s  = 1'b0;
        sel_respack_s = 1'b0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            grant_idx_s   = grant_idx_s | (grant_r[i] ? PTR_W'(i) : '0);
            sel_req_s     = sel_req_s | (c_req[i*DATA_W +: DATA_W] & {DATA_W{grant_r[i]}});
            sel_tag_s     = sel_tag_s | (c_reqtag[i*TAG_W +: TAG_W] & {TAG_W{grant_r[i]}});
            sel_reqcyc_s  = sel_reqcyc_s | (c_reqcyc[i] & grant_r[i]);
            sel_respack_s = sel_respack_s | (c_respack[i] & grant_r[i]);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) state_nxt_s = ADDR;
                else           state_nxt_s = IDLE;
            end
            ADDR: begin
                if (req_beat_s) state_nxt_s = is_read_r ? RDATA : WDATA;
                else            state_nxt_s = ADDR;
            end
            WDATA: begin
                if (req_beat_s && last_beat_s) state_nxt_s = IDLE;
                else                           state_nxt_s = WDATA;
            end
            RDATA: begin
                if (resp_beat_s && last_beat_s) state_nxt_s = IDLE;
                else                            state_nxt_s = RDATA;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs: forward the grantee's request or response path only.
    always_comb begin
        m_req     = '0;
        m_reqtag  = '0;
        m_reqcyc  = 1'b0;
        m_respack = 1'b0;
        c_reqack  = '0;
        c_respcyc = '0;
        case (state_r)
            ADDR, WDATA: begin
                m_req    = sel_req_s;
                m_reqtag = sel_tag_s;
                m_reqcyc = sel_reqcyc_s;
                c_reqack = grant_r & {N_CLIENTS{req_beat_s}};
            end
            RDATA: begin
                c_respcyc = grant_r & {N_CLIENTS{m_respcyc}};
                m_respack = sel_respack_s;
            end
            IDLE: begin
                m_reqcyc = 1'b0;
            end
            default: begin
                m_reqcyc = 1'b0;
            end
        endcase
    end

    // Grant, transaction kind and round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_r   <= '0;
            is_read_r <= 1'b0;
            rr_ptr_r  <= '0;
        end else if ((state_r == IDLE) && any_req_s) begin
            grant_r   <= winner_s;
            is_read_r <= win_rd_s;
        end else if (txn_done_s) begin
            grant_r  <= '0;
            rr_ptr_r <= ptr_next_s;
        end else begin
            grant_r <= grant_r;
        end
    end

    // Data beat counter; cleared by the address beat, never wraps past the last beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_cnt_r <= '0;
        end else if ((state_r == ADDR) && req_beat_s) begin
            beat_cnt_r <= '0;
        end else if (((state_r == WDATA) && req_beat_s) || ((state_r == RDATA) && resp_beat_s)) begin
            beat_cnt_r <= last_beat_s ? '0 : beat_cnt_r + BEAT_W'(1);
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end

    // Response arriving with no read burst in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stray_r <= 1'b0;
        end else begin
            stray_r <= m_respcyc && (state_r != RDATA);
        end
    end

    assign c_resp     = m_resp;
    assign m_bid      = (state_r != IDLE) | (|c_bid) | any_req_s;
    assign grant      = grant_r;
    assign stray_resp = stray_r;

endmodule

// File: tb/tb_muskbus_arbiter.sv
// Scoreboard bench for muskbus_arbiter: client and downstream models, expected
// beats queued when transactions start and checked as the DUT moves them.
module tb_muskbus_arbiter;

    localparam int N = 2;
    localparam int B = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      c_bid;
    logic [64*N-1:0]   c_req;
    logic [13*N-1:0]   c_reqtag;
    logic [N-1:0]      c_reqcyc;
    logic [N-1:0]      c_reqack;
    logic [63:0]       c_resp;
    logic [N-1:0]      c_respcyc;
    logic [N-1:0]      c_respack;
    logic              m_bid;
    logic [63:0]       m_req;
    logic [12:0]       m_reqtag;
    logic              m_reqcyc;
    logic              m_respack;
    logic              m_reqack;
    logic [63:0]       m_resp;
    logic              m_respcyc;
    logic [N-1:0]      grant;
    logic              stray_resp;

    always #5 clk = ~clk;

    muskbus_arbiter #(.N_CLIENTS(N), .BEATS(B)) dut (
        .clk(clk), .reset(reset), .c_bid(c_bid), .c_req(c_req), .c_reqtag(c_reqtag),
        .c_reqcyc(c_reqcyc), .c_reqack(c_reqack), .c_resp(c_resp), .c_respcyc(c_respcyc),
        .c_respack(c_respack), .m_bid(m_bid), .m_req(m_req), .m_reqtag(m_reqtag),
        .m_reqcyc(m_reqcyc), .m_respack(m_respack), .m_reqack(m_reqack), .m_resp(m_resp),
        .m_respcyc(m_respcyc), .grant(grant), .stray_resp(stray_resp)
    );

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    int done_cyc = -10;
    int grant_cyc = 0;
    logic first_mreqcyc;

    bit          act [N];
    bit          rd  [N];
    logic [12:0] tg  [N];
    logic [63:0] ad  [N];
    int ph [N];
    int kb [N];
    int rc [N];
    int rep [N];
    int seq [N];
    int acks [N];
    int beats_ok [N];

    logic [76:0] dq [$];
    logic [67:0] rq [$];
    logic [N-1:0] gq [$];
    logic [N-1:0] cur_mask;
    int owner;

    int resp_pend, resp_k, dn_wleft, stall_left;
    logic [63:0] resp_base;
    logic [63:0] mresp_drv;
    bit stray_force;
    logic [N-1:0] bid_drv;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] wdata(input logic [63:0] a, input int k);
        return a + 64'h5555_0000_0000_0000 + 64'(k);
    endfunction

    function automatic logic [63:0] rword(input logic [63:0] a, input int k);
        return {a[31:0], a[63:32]} ^ (64'h1111 * 64'(k + 1));
    endfunction

    task automatic start_tr(input int i, input bit is_rd, input logic [12:0] tag);
        act[i] = 1'b1;
        rd[i]  = is_rd;
        tg[i]  = tag;
        ad[i]  = 64'hA000_0000_0000_0000 | (64'(i) << 32) | (64'(seq[i]) << 8);
        seq[i]++;
        ph[i] = 0;
        kb[i] = 0;
        rc[i] = 0;
    endtask

    task automatic finish_tr(input int i);
        act[i] = 1'b0;
        if (cur_mask[i]) begin
            cur_mask = '0;
            done_cyc = cyc;
        end
        rep[i]--;
        if (rep[i] > 0) start_tr(i, rd[i], tg[i]);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            c_reqcyc[i]          = act[i] && (ph[i] != 2);
            c_req[i*64 +: 64]    = (ph[i] == 0) ? ad[i] : wdata(ad[i], kb[i]);
            c_reqtag[i*13 +: 13] = tg[i];
            c_respack[i]         = ($urandom_range(0, 3) != 0);
        end
        c_bid     = bid_drv;
        m_reqack  = (stall_left == 0);
        m_respcyc = (resp_pend > 0) || stray_force;
        m_resp    = (resp_pend > 0) ? rword(resp_base, resp_k) : 64'hFEED_0000_CAFE_0001;
        mresp_drv = m_resp;
    endtask

    task automatic observe();
        logic [N-1:0] exp_g;
        logic [76:0]  e;
        logic [67:0]  r;
        cyc++;
        if (grant != '0 && cur_mask == '0) begin
            exp_g = (gq.size() > 0) ? gq.pop_front() : '0;
            chk("grant", 64'(grant), 64'(exp_g));
            chk("bubble", 64'(cyc - done_cyc >= 2), 64'd1);
            grant_cyc     = cyc;
            first_mreqcyc = m_reqcyc;
            cur_mask      = exp_g;
            for (int j = 0; j < N; j++) if (exp_g[j]) owner = j;
            if (exp_g != '0) begin
                dq.push_back({tg[owner], ad[owner]});
                if (!rd[owner]) for (int k = 0; k < B; k++) dq.push_back({tg[owner], wdata(ad[owner], k)});
            end
        end else begin
            chk("grant_hold", 64'(grant), 64'(cur_mask));
        end
        chk("xack", 64'(c_reqack & ~cur_mask), 64'd0);
        chk("xresp", 64'(c_respcyc & ~cur_mask), 64'd0);
        if (cur_mask != '0 && ph[owner] == 2) begin
            chk("respcyc_fwd", 64'(c_respcyc[owner]), 64'(m_respcyc));
            chk("respack_fwd", 64'(m_respack), 64'(c_respack[owner]));
        end
        // Downstream slave model.
        if (m_reqcyc && m_reqack) begin
            if (dq.size() == 0) begin
                chk("dq_empty", 64'd1, 64'd0);
            end else begin
                e = dq.pop_front();
                chk("m_req", m_req, e[63:0]);
                chk("m_reqtag", 64'(m_reqtag), 64'(e[76:64]));
            end
            if (dn_wleft == 0) begin
                if (m_reqtag[12]) begin
                    resp_pend = B;
                    resp_k    = 0;
                    resp_base = m_req;
                    for (int k = 0; k < B; k++) rq.push_back({4'(owner), rword(ad[owner], k)});
                end else begin
                    dn_wleft = B;
                end
            end else begin
                dn_wleft--;
            end
        end
        if (stall_left > 0 && stall_left < 20) chk("stall_reqcyc", 64'(m_reqcyc), 64'd1);
        if (stall_left > 0 && (m_reqcyc || stall_left < 20)) stall_left--;
        if (m_respcyc && m_respack && resp_pend > 0) begin
            resp_pend--;
            resp_k++;
        end
        // Client models.
        for (int i = 0; i < N; i++) begin
            if (act[i] && ph[i] != 2 && c_reqack[i]) begin
                acks[i]++;
                if (ph[i] == 0) begin
                    if (rd[i]) ph[i] = 2;
                    else begin ph[i] = 1; kb[i] = 0; end
                end else begin
                    kb[i]++;
                    if (kb[i] == B) finish_tr(i);
                end
            end else if (act[i] && ph[i] == 2 && c_respcyc[i] && c_respack[i]) begin
                beats_ok[i]++;
                if (rq.size() == 0) begin
                    chk("rq_empty", 64'd1, 64'd0);
                end else begin
                    r = rq.pop_front();
                    chk("resp_who", 64'(r[67:64]), 64'(i));
                    chk("c_resp", c_resp, r[63:0]);
                end
                rc[i]++;
                if (rc[i] == B) finish_tr(i);
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        drive();
        #1;
        observe();
    endtask

    function automatic bit busy();
        bit b = (resp_pend > 0);
        for (int i = 0; i < N; i++) b = b | act[i];
        return b;
    endfunction

    task automatic run(input int budget);
        int n = 0;
        while (busy() && n < budget) begin
            cycle();
            chk("stray_quiet", 64'(stray_resp), 64'd0);
            n++;
        end
        chk("timeout", 64'(busy()), 64'd0);
        chk("dq_left", 64'(dq.size()), 64'd0);
        chk("rq_left", 64'(rq.size()), 64'd0);
        chk("gq_left", 64'(gq.size()), 64'd0);
        cycle();
        chk("idle_grant", 64'(grant), 64'd0);
    endtask

    task automatic clear_models();
        for (int i = 0; i < N; i++) begin
            act[i] = 1'b0; rep[i] = 0; ph[i] = 0; acks[i] = 0; beats_ok[i] = 0;
        end
        dq.delete(); rq.delete(); gq.delete();
        cur_mask = '0; resp_pend = 0; dn_wleft = 0; stall_left = 0;
        done_cyc = cyc - 10;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_grant"}, 64'(grant), 64'd0);
        chk({tag, "_mreqcyc"}, 64'(m_reqcyc), 64'd0);
        chk({tag, "_mreq"}, m_req, 64'd0);
        chk({tag, "_mreqtag"}, 64'(m_reqtag), 64'd0);
        chk({tag, "_creqack"}, 64'(c_reqack), 64'd0);
        chk({tag, "_crespcyc"}, 64'(c_respcyc), 64'd0);
        chk({tag, "_mrespack"}, 64'(m_respack), 64'd0);
        chk({tag, "_mbid"}, 64'(m_bid), 64'd0);
        chk({tag, "_stray"}, 64'(stray_resp), 64'd0);
        chk({tag, "_cresp"}, c_resp, mresp_drv);
    endtask

    initial begin
        int n;
        reset = 1'b0;
        bid_drv = '0;
        stray_force = 1'b0;
        for (int i = 0; i < N; i++) begin tg[i] = '0; ad[i] = '0; seq[i] = 0; end
        clear_models();
        drive();
        #12;
        check_quiet("rst");
        @(negedge clk);
        reset = 1'b1;

        // Single read, client 0.
        clear_models();
        start_tr(0, 1'b1, 13'h1100); rep[0] = 1; gq.push_back(2'b01);
        n = cyc + 1;
        run(300);
        chk("arb_lat", 64'(grant_cyc - n), 64'd1);
        chk("arb_mreqcyc", 64'(first_mreqcyc), 64'd1);
        chk("rd_beats", 64'(beats_ok[0]), 64'd8);

        // Single write, client 1.
        clear_models();
        start_tr(1, 1'b0, 13'h0100); rep[1] = 1; gq.push_back(2'b10);
        run(300);
        chk("wr_acks", 64'(acks[1]), 64'd9);
        chk("wr_acks_other", 64'(acks[0]), 64'd0);

        // Both clients reading continuously: grants alternate.
        clear_models();
        start_tr(0, 1'b1, 13'h1000); rep[0] = 2;
        start_tr(1, 1'b1, 13'h1001); rep[1] = 2;
        gq.push_back(2'b01); gq.push_back(2'b10); gq.push_back(2'b01); gq.push_back(2'b10);
        run(600);

        // Response with nothing outstanding.
        clear_models();
        bid_drv = 2'b10; stray_force = 1'b1;
        cycle();
        chk("bid_only", 64'(m_bid), 64'd1);
        chk("stray_nocyc", 64'(c_respcyc), 64'd0);
        chk("stray_noack", 64'(m_respack), 64'd0);
        chk("stray_early", 64'(stray_resp), 64'd0);
        bid_drv = '0; stray_force = 1'b0;
        cycle();
        chk("stray_pulse", 64'(stray_resp), 64'd1);
        chk("stray_grant", 64'(grant), 64'd0);
        chk("bid_idle", 64'(m_bid), 64'd0);
        cycle();
        chk("stray_clear", 64'(stray_resp), 64'd0);

        // Downstream stalls the address beat for 20 cycles.
        clear_models();
        stall_left = 20;
        start_tr(0, 1'b0, 13'h0042); rep[0] = 1;
        start_tr(1, 1'b1, 13'h1042); rep[1] = 1;
        gq.push_back(2'b01); gq.push_back(2'b10);
        run(600);
        chk("stall_done", 64'(stall_left), 64'd0);

        // Reset in the middle of a read burst.
        clear_models();
        start_tr(0, 1'b1, 13'h1200); rep[0] = 1; gq.push_back(2'b01);
        run(300);
        clear_models();
        start_tr(0, 1'b1, 13'h1201); rep[0] = 1; gq.push_back(2'b01);
        n = 0;
        while (rc[0] < 3 && n < 200) begin cycle(); n++; end
        chk("rd3_reached", 64'(rc[0]), 64'd3);
        #2;
        reset = 1'b0;
        #1;
        check_quiet("midrst");
        clear_models();
        @(negedge clk);
        drive();
        @(negedge clk);
        reset = 1'b1;
        start_tr(0, 1'b1, 13'h1300); rep[0] = 1;
        start_tr(1, 1'b1, 13'h1301); rep[1] = 1;
        gq.push_back(2'b01); gq.push_back(2'b10);
        run(600);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
